// File: rtl/mcpu_control_fsm.sv
// rtl/mcpu_control_fsm.sv - multicycle CPU control FSM: state register plus combinational control decode
module mcpu_control_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        zero,
    output logic [3:0]  state,
    output logic        pc_we,
    output logic        ir_we,
    output logic        a_we,
    output logic        b_we,
    output logic        mem_we,
    output logic        reg_we,
    output logic        mem_in,
    output logic        dst,
    output logic        reg_in,
    output logic        immer,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic        beq_bne,
    output logic        jal,
    output logic        instr_done,
    output logic        halted
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_JAL      = 4'd11,
        S_JR       = 4'd12,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_JR   = 6'h08;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;

    state_t r_state;
    state_t w_next;

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic       w_unused_ir;
    logic       w_is_r;
    logic       w_fn_alu;
    logic       w_fn_jr;
    logic       w_is_bne;
    logic       w_is_xori;

    logic       w_pc_we;
    logic       w_ir_we;
    logic       w_a_we;
    logic       w_b_we;
    logic       w_mem_we;
    logic       w_reg_we;

    assign w_opcode    = instruction[31:26];
    assign w_funct     = instruction[5:0];
    // rs/rt/rd/shamt fields are consumed by the datapath, not by control
    assign w_unused_ir = ^instruction[25:6];

    assign w_is_r    = (w_opcode == OP_R);
    assign w_fn_alu  = (w_funct == FN_ADD) || (w_funct == FN_SUB) || (w_funct == FN_SLT);
    assign w_fn_jr   = (w_funct == FN_JR);
    assign w_is_bne  = (w_opcode == OP_BNE);
    assign w_is_xori = (w_opcode == OP_XORI);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_HALT;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (w_opcode)
                    OP_LW, OP_SW:     w_next = S_MEM_ADDR;
                    OP_R: begin
                        if (w_fn_alu)     w_next = S_EXEC_R;
                        else if (w_fn_jr) w_next = S_JR;
                        else              w_next = S_HALT;
                    end
                    OP_ADDI, OP_XORI: w_next = S_EXEC_I;
                    OP_BEQ, OP_BNE:   w_next = S_BRANCH;
                    OP_J:             w_next = S_JUMP;
                    OP_JAL:           w_next = S_JAL;
                    default:          w_next = S_HALT;
                endcase
            end
            S_MEM_ADDR: begin
                if (w_opcode == OP_LW)      w_next = S_MEM_RD;
                else if (w_opcode == OP_SW) w_next = S_MEM_WR;
                else                        w_next = S_HALT;
            end
            S_MEM_RD: w_next = S_MEM_WB;
            S_EXEC_R: w_next = S_ALU_WB;
            S_EXEC_I: w_next = S_ALU_WB;
            S_MEM_WB, S_MEM_WR, S_ALU_WB, S_BRANCH,
            S_JUMP, S_JAL, S_JR: w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_HALT;
        endcase
    end

    always_comb begin
        w_pc_we    = 1'b0;
        w_ir_we    = 1'b0;
        w_a_we     = 1'b0;
        w_b_we     = 1'b0;
        w_mem_we   = 1'b0;
        w_reg_we   = 1'b0;
        mem_in     = 1'b0;
        dst        = 1'b0;
        reg_in     = 1'b0;
        immer      = 1'b0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        alu_op     = ALU_ADD;
        pc_src     = 2'd0;
        beq_bne    = 1'b0;
        jal        = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_we   = 1'b1;
                w_pc_we   = 1'b1;
                alu_src_b = 2'd3;
                pc_src    = 2'd2;
            end
            S_DECODE: begin
                w_a_we = 1'b1;
                w_b_we = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
            end
            S_MEM_RD: mem_in = 1'b1;
            S_MEM_WB: begin
                w_reg_we   = 1'b1;
                dst        = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                mem_in     = 1'b1;
                w_mem_we   = 1'b1;
                instr_done = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                if (w_funct == FN_SUB)      alu_op = ALU_SUB;
                else if (w_funct == FN_SLT) alu_op = ALU_SLT;
                else                        alu_op = ALU_ADD;
            end
            S_EXEC_I: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                alu_op    = w_is_xori ? ALU_XOR : ALU_ADD;
                immer     = w_is_xori;
            end
            // immer stays valid through writeback so the immediate path is stable
            S_ALU_WB: begin
                w_reg_we   = 1'b1;
                reg_in     = 1'b1;
                dst        = !w_is_r;
                immer      = w_is_xori;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 2'd1;
                alu_src_b  = 2'd2;
                alu_op     = ALU_SUB;
                pc_src     = 2'd3;
                beq_bne    = w_is_bne;
                w_pc_we    = zero ^ w_is_bne;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                w_pc_we    = 1'b1;
                pc_src     = 2'd1;
                instr_done = 1'b1;
            end
            S_JAL: begin
                w_pc_we    = 1'b1;
                pc_src     = 2'd1;
                w_reg_we   = 1'b1;
                jal        = 1'b1;
                instr_done = 1'b1;
            end
            S_JR: begin
                alu_src_a  = 2'd1;
                alu_src_b  = 2'd2;
                pc_src     = 2'd2;
                w_pc_we    = 1'b1;
                instr_done = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: halted = 1'b1;
        endcase
    end

    // write enables are masked by reset so nothing commits while it is held
    assign pc_we  = w_pc_we  & reset;
    assign ir_we  = w_ir_we  & reset;
    assign a_we   = w_a_we   & reset;
    assign b_we   = w_b_we   & reset;
    assign mem_we = w_mem_we & reset;
    assign reg_we = w_reg_we & reset;

    assign state = r_state;

endmodule

// File: tb/tb_mcpu_control_fsm.sv
// tb/tb_mcpu_control_fsm.sv - self-checking bench for mcpu_control_fsm against an instruction-level model
module tb_mcpu_control_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instruction = 32'h0;
    logic        zero = 1'b0;
    logic [3:0]  state;
    logic        pc_we, ir_we, a_we, b_we, mem_we, reg_we;
    logic        mem_in, dst, reg_in, immer;
    logic [1:0]  alu_src_a, alu_src_b, pc_src;
    logic [2:0]  alu_op;
    logic        beq_bne, jal, instr_done, halted;

    int checks = 0;
    int failures = 0;

    localparam logic [22:0] WE_MASK = 23'h7E0000;

    mcpu_control_fsm dut (
        .clk(clk), .reset(reset), .instruction(instruction), .zero(zero),
        .state(state), .pc_we(pc_we), .ir_we(ir_we), .a_we(a_we), .b_we(b_we),
        .mem_we(mem_we), .reg_we(reg_we), .mem_in(mem_in), .dst(dst),
        .reg_in(reg_in), .immer(immer), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .beq_bne(beq_bne), .jal(jal), .instr_done(instr_done), .halted(halted)
    );

    always #5 clk = ~clk;

    logic [22:0] dut_vec;
    assign dut_vec = {pc_we, ir_we, a_we, b_we, mem_we, reg_we, mem_in, dst, reg_in, immer,
                      alu_src_a, alu_src_b, alu_op, pc_src, beq_bne, jal, instr_done, halted};

    // Path of state codes an instruction walks, from its opcode/funct class
    function automatic int path_at(input logic [31:0] ins, input int i);
        int p[$];
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        p.push_back(0);
        p.push_back(1);
        if (op == 6'h23) begin p.push_back(2); p.push_back(3); p.push_back(4); end
        else if (op == 6'h2B) begin p.push_back(2); p.push_back(5); end
        else if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A)) begin p.push_back(6); p.push_back(8); end
        else if (op == 6'h00 && fn == 6'h08) p.push_back(12);
        else if (op == 6'h08 || op == 6'h0E) begin p.push_back(7); p.push_back(8); end
        else if (op == 6'h04 || op == 6'h05) p.push_back(9);
        else if (op == 6'h02) p.push_back(10);
        else if (op == 6'h03) p.push_back(11);
        else p.push_back(15);
        if (i < p.size()) return p[i];
        return (p[p.size()-1] == 15) ? 15 : 0;
    endfunction

    function automatic int path_len(input logic [31:0] ins);
        for (int l = 1; l < 8; l++) begin
            if (path_at(ins, l) == 0) return l;
            if (path_at(ins, l) == 15) return l + 1;
        end
        return 8;
    endfunction

    function automatic logic [22:0] exp_out(input int st, input logic [31:0] ins, input logic z);
        logic pw, iw, aw, bw, mw, rw, mi, d, ri, im, bb, jl, dn, hl;
        logic [1:0] sa, sb, ps;
        logic [2:0] op;
        logic [5:0] opc;
        logic [5:0] fn;
        opc = ins[31:26];
        fn = ins[5:0];
        {pw, iw, aw, bw, mw, rw, mi, d, ri, im, bb, jl, dn, hl} = '0;
        sa = 0; sb = 0; ps = 0; op = 0;
        case (st)
            0:  begin pw = 1; iw = 1; sb = 3; ps = 2; end
            1:  begin aw = 1; bw = 1; end
            2:  begin sa = 1; sb = 1; end
            3:  mi = 1;
            4:  begin rw = 1; d = 1; dn = 1; end
            5:  begin mi = 1; mw = 1; dn = 1; end
            6:  begin sa = 1; sb = 2; op = (fn == 6'h22) ? 3'd1 : (fn == 6'h2A) ? 3'd3 : 3'd0; end
            7:  begin sa = 1; sb = 1; op = (opc == 6'h0E) ? 3'd2 : 3'd0; im = (opc == 6'h0E); end
            8:  begin rw = 1; ri = 1; d = (opc != 6'h00); im = (opc == 6'h0E); dn = 1; end
            9:  begin sa = 1; sb = 2; op = 1; ps = 3; bb = (opc == 6'h05); pw = z ^ bb; dn = 1; end
            10: begin pw = 1; ps = 1; dn = 1; end
            11: begin pw = 1; ps = 1; rw = 1; jl = 1; dn = 1; end
            12: begin sa = 1; sb = 2; ps = 2; pw = 1; dn = 1; end
            default: hl = 1;
        endcase
        return {pw, iw, aw, bw, mw, rw, mi, d, ri, im, sa, sb, op, ps, bb, jl, dn, hl};
    endfunction

    int          obs_st[$];
    logic [22:0] obs_vec[$];
    logic        obs_z[$];

    // Runs n cycles from FETCH, recording what the DUT shows; called at a falling edge
    task automatic exec_instr(input logic [31:0] ins, input int zmode, input int n);
        obs_st.delete();
        obs_vec.delete();
        obs_z.delete();
        instruction = ins;
        for (int i = 0; i < n; i++) begin
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
            #1;
            obs_st.push_back(int'(state));
            obs_vec.push_back(dut_vec);
            obs_z.push_back(zero);
            @(negedge clk);
        end
        #1;
        obs_st.push_back(int'(state));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (state !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++;
        if (dut_vec !== (exp_out(0, 32'h0, 1'b0) & ~WE_MASK)) begin
            failures++; $display("FAIL reset_outputs got=%h exp=%h", dut_vec, exp_out(0, 32'h0, 1'b0) & ~WE_MASK);
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (state !== 4'd1) begin failures++; $display("FAIL reset_release got=%0d exp=1", state); end
        do_reset();
    endtask

    task automatic test_directed();
        logic [31:0] tab_ins[15] = '{32'h8C220004, 32'hAC220004, 32'h14220003, 32'h14220003,
                                     32'h10220003, 32'h10220003, 32'h00221820, 32'h00221822,
                                     32'h0022182A, 32'h03E00008, 32'h20220005, 32'h3822FFFF,
                                     32'h08000010, 32'h0C000010, 32'h8C220004};
        int tab_z[15] = '{2, 2, 1, 0, 1, 0, 2, 2, 2, 2, 2, 2, 2, 2, 2};
        int n, dones;
        for (int t = 0; t < 15; t++) begin
            n = path_len(tab_ins[t]);
            exec_instr(tab_ins[t], tab_z[t], n);
            dones = 0;
            for (int i = 0; i <= n; i++) begin
                checks++;
                if (obs_st[i] != path_at(tab_ins[t], i)) begin
                    failures++;
                    $display("FAIL dir_state ins=%h cyc=%0d got=%0d exp=%0d", tab_ins[t], i, obs_st[i], path_at(tab_ins[t], i));
                end
                if (i < n) begin
                    checks++;
                    if (obs_vec[i] !== exp_out(path_at(tab_ins[t], i), tab_ins[t], obs_z[i])) begin
                        failures++;
                        $display("FAIL dir_outputs ins=%h cyc=%0d got=%h exp=%h", tab_ins[t], i, obs_vec[i],
                                 exp_out(path_at(tab_ins[t], i), tab_ins[t], obs_z[i]));
                    end
                    dones += int'(obs_vec[i][1]);
                end
            end
            checks++;
            if (dones != 1) begin failures++; $display("FAIL dir_done_pulses ins=%h got=%0d exp=1", tab_ins[t], dones); end
        end
    endtask

    task automatic test_reset_mid_mem_rd();
        instruction = 32'h8C220004;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (state !== 4'd3) begin failures++; $display("FAIL midrd_reach got=%0d exp=3", state); end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0) begin failures++; $display("FAIL midrd_async got=%0d exp=0", state); end
        checks++;
        if ((dut_vec & WE_MASK) !== 23'h0) begin failures++; $display("FAIL midrd_enables got=%h exp=0", dut_vec & WE_MASK); end
        @(negedge clk);
        checks++;
        if (state !== 4'd0 || (dut_vec & WE_MASK) !== 23'h0) begin
            failures++; $display("FAIL midrd_hold got_state=%0d got_we=%h exp_state=0 exp_we=0", state, dut_vec & WE_MASK);
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (state !== 4'd1) begin failures++; $display("FAIL midrd_release got=%0d exp=1", state); end
        do_reset();
    endtask

    task automatic test_halt();
        logic [31:0] ins;
        ins = 32'hFC000000;
        exec_instr(ins, 2, 13);
        for (int i = 0; i <= 13; i++) begin
            checks++;
            if (obs_st[i] != path_at(ins, i)) begin
                failures++; $display("FAIL halt_state cyc=%0d got=%0d exp=%0d", i, obs_st[i], path_at(ins, i));
            end
            if (i < 13) begin
                checks++;
                if (obs_vec[i] !== exp_out(path_at(ins, i), ins, obs_z[i])) begin
                    failures++; $display("FAIL halt_outputs cyc=%0d got=%h exp=%h", i, obs_vec[i], exp_out(path_at(ins, i), ins, obs_z[i]));
                end
            end
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || halted !== 1'b0) begin
            failures++; $display("FAIL halt_reset got_state=%0d got_halted=%b exp_state=0 exp_halted=0", state, halted);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic [5:0] ops[9] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0E, 6'h23, 6'h2B};
        logic [5:0] fns[4] = '{6'h20, 6'h22, 6'h2A, 6'h08};
        logic [31:0] ins;
        int n;
        for (int t = 0; t < 60; t++) begin
            ins = $urandom();
            if ($urandom_range(0, 7) != 0) ins[31:26] = ops[$urandom_range(0, 8)];
            if (ins[31:26] == 6'h00 && $urandom_range(0, 3) != 0) ins[5:0] = fns[$urandom_range(0, 3)];
            n = path_len(ins);
            if (path_at(ins, n - 1) == 15) n = n + 3;
            exec_instr(ins, 2, n);
            for (int i = 0; i <= n; i++) begin
                checks++;
                if (obs_st[i] != path_at(ins, i)) begin
                    failures++; $display("FAIL rnd_state ins=%h cyc=%0d got=%0d exp=%0d", ins, i, obs_st[i], path_at(ins, i));
                end
                if (i < n) begin
                    checks++;
                    if (obs_vec[i] !== exp_out(path_at(ins, i), ins, obs_z[i])) begin
                        failures++;
                        $display("FAIL rnd_outputs ins=%h cyc=%0d got=%h exp=%h", ins, i, obs_vec[i], exp_out(path_at(ins, i), ins, obs_z[i]));
                    end
                end
            end
            if (path_at(ins, n) == 15) do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_mem_rd();
        test_halt();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/mcpu_control_fsm.md
MCPU_CONTROL_FSM -- requirements
Module: mcpu_control_fsm

Interface
REQ-001 Parameter: none; all encodings are fixed by this spec.
REQ-002 clk  in  1  single system clock, rising-edge active.
REQ-003 reset  in  1  asynchronous, active-low (0 = reset asserted).
REQ-004 instruction  in  32  IR register output; opcode [31:26], rt [20:16], funct [5:0].
REQ-005 zero  in  1  ALU zero flag.
REQ-006 state  out  4  current state code.
REQ-007 pc_we, ir_we, a_we, b_we, mem_we, reg_we  out  1 each  register and memory write enables.
REQ-008 mem_in  out  1  memory address select: 0 = PC, 1 = ALU register.
REQ-009 dst  out  1  write-register select: 0 = rd, 1 = rt.
REQ-010 reg_in  out  1  write-data select: 0 = MDR, 1 = ALU register.
REQ-011 immer  out  1  immediate extension: 1 = zero-extend, 0 = sign-extend.
REQ-012 alu_src_a  out  2  ALU A select: 0 = PC, 1 = A, 2 = BEN register, 3 = zero.
REQ-013 alu_src_b  out  2  ALU B select: 0 = imm<<2, 1 = imm32, 2 = B, 3 = constant 4.
REQ-014 alu_op  out  3  ALU command: ADD=000, SUB=001, XOR=010, SLT=011.
REQ-015 pc_src  out  2  PC source: 0 = branch mux, 1 = jump concat, 2 = ALU out, 3 = ALU register.
REQ-016 beq_bne, jal  out  1 each  1 = BNE; 1 = JAL write ($31 <- PC).
REQ-017 instr_done, halted  out  1 each  final-cycle pulse; HALT indicator.

Function
REQ-018 States SHALL be FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, JUMP=10, JAL=11, JR=12, HALT=15; codes 13 and 14 SHALL go to HALT.
REQ-019 Opcodes: R=0x00, J=0x02, JAL=0x03, BEQ=0x04, BNE=0x05, ADDI=0x08, XORI=0x0E, LW=0x23, SW=0x2B. R-type funct: ADD=0x20, SUB=0x22, SLT=0x2A, JR=0x08.
REQ-020 Transitions: FETCH->DECODE.
REQ-021 From DECODE: LW or SW -> MEM_ADDR; R-type with legal non-JR funct -> EXEC_R; JR -> JR; ADDI or XORI -> EXEC_I; BEQ or BNE -> BRANCH; J -> JUMP; JAL -> JAL; any other opcode or funct -> HALT.
REQ-022 From MEM_ADDR: LW -> MEM_RD, SW -> MEM_WR.
REQ-023 MEM_RD->MEM_WB, EXEC_R->ALU_WB, EXEC_I->ALU_WB.
REQ-024 MEM_WB, MEM_WR, ALU_WB, BRANCH, JUMP, JAL and JR SHALL each go to FETCH.
REQ-025 HALT SHALL hold until reset.
REQ-026 Outputs SHALL be combinational decodes of state, opcode, funct and zero; every output not listed for a state SHALL be 0.
REQ-027 FETCH: ir_we=1, pc_we=1, mem_in=0, alu_src_a=0, alu_src_b=3, alu_op=ADD, pc_src=2.
REQ-028 DECODE: a_we=1, b_we=1, alu_src_a=0, alu_src_b=0, alu_op=ADD (branch target into the ALU register).
REQ-029 MEM_ADDR: alu_src_a=1, alu_src_b=1, alu_op=ADD.
REQ-030 MEM_RD: mem_in=1. MEM_WB: reg_we=1, dst=1, reg_in=0. MEM_WR: mem_in=1, mem_we=1.
REQ-031 EXEC_R: alu_src_a=1, alu_src_b=2, alu_op from funct (ADD=000, SUB=001, SLT=011).
REQ-032 EXEC_I: alu_src_a=1, alu_src_b=1; ADDI gives alu_op=ADD, immer=0; XORI gives alu_op=XOR, immer=1.
REQ-033 ALU_WB: reg_we=1, reg_in=1, dst=0 for R-type, dst=1 for I-type; immer SHALL hold its EXEC_I value.
REQ-034 BRANCH: alu_src_a=1, alu_src_b=2, alu_op=SUB, pc_src=3, beq_bne=(opcode==BNE), pc_we=zero XOR beq_bne.
REQ-035 JUMP: pc_we=1, pc_src=1. JAL: pc_we=1, pc_src=1, reg_we=1, jal=1.
REQ-036 JR: alu_src_a=1, alu_src_b=2, alu_op=ADD (rt=$zero), pc_src=2, pc_we=1.
REQ-037 instr_done SHALL be 1 only in the final state of an instruction (REQ-024 list), for exactly 1 cycle; halted=1 only in HALT, where all enables SHALL be 0.
REQ-038 Latency in cycles: LW 5, SW 4, R/I ALU 4, BEQ/BNE/J/JAL/JR 3.

Reset
REQ-039 reset=0 SHALL force state=FETCH immediately, independent of clk, and SHALL hold every write enable (pc_we, ir_we, a_we, b_we, mem_we, reg_we) at 0 while asserted; all other outputs SHALL take their FETCH values.
REQ-040 After reset is released, the first rising edge SHALL move FETCH->DECODE; a reset in any state, including HALT, SHALL abort the instruction with no further writes.

Verification
REQ-041 Drive reset=0 mid-MEM_RD -> state=0 with no clock edge; all write enables 0; after release, the next edge gives state=1.
REQ-042 LW 0x8C220004 -> state sequence 0,1,2,3,4,0; reg_we=1 only in state 4 with dst=1, reg_in=0; instr_done high 1 cycle.
REQ-043 BNE 0x14220003: zero=1 -> pc_we=0 in state 9; zero=0 -> pc_we=1, pc_src=3, beq_bne=1.
REQ-044 R-type funct 0x20 gives alu_op=000, funct 0x2A gives alu_op=011 in state 6; state 8 has dst=0, reg_in=1, reg_we=1.
REQ-045 JAL 0x0C000010 -> states 0,1,11,0; in state 11 pc_we=1, pc_src=1, jal=1, reg_we=1.
REQ-046 Opcode 0x3F -> state 15 held for 10 or more cycles with halted=1 and all enables 0; reset=0 returns state to 0.
